// File: rtl/mux_nto1_stream.sv
// N-input valid/ready stream mux: explicit-select or round-robin channel choice, registered output stage.
// Define MUX_NTO1_LAST_LOCK_EN to hold the granted channel until its in_last beat (packet lock).
module mux_nto1_stream #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SEL_WIDTH-1:0]    sel,
  input  logic                    arb_mode,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_WIDTH-1:0]    out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic [SEL_WIDTH-1:0] out_ch_q, out_ch_d;
  logic                 out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

`ifdef MUX_NTO1_LAST_LOCK_EN
  logic                 lock_q, lock_d;
  logic [SEL_WIDTH-1:0] lock_ch_q, lock_ch_d;
`endif

  logic [NUM_CH-1:0]    grant;
  logic                 rr_found;
  int unsigned          rr_idx;
  logic [SEL_WIDTH-1:0] gnt_idx;
  logic [WIDTH-1:0]     gnt_data;
  logic                 gnt_last;
  logic                 load_ok;
  logic                 accept;

  // Grant: one-hot or zero; round-robin search starts at rr_ptr and wraps.
  always_comb begin
    grant    = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    if (!arb_mode) begin
      if (32'(sel) < NUM_CH) grant[sel] = in_valid[sel];
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        rr_idx = (32'(rr_ptr_q) + k) % NUM_CH;
        if (!rr_found && in_valid[SEL_WIDTH'(rr_idx)]) begin
          grant[SEL_WIDTH'(rr_idx)] = 1'b1;
          rr_found                  = 1'b1;
        end
      end
    end
`ifdef MUX_NTO1_LAST_LOCK_EN
    if (lock_q) begin
      grant            = '0;
      grant[lock_ch_q] = in_valid[lock_ch_q];
    end
`endif
  end

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        gnt_idx  = SEL_WIDTH'(i);
        gnt_data = in_data[i*WIDTH +: WIDTH];
        gnt_last = in_last[i];
      end
    end
  end

  assign load_ok  = !out_valid_q || out_ready;
  assign in_ready = grant & {NUM_CH{load_ok & rst_n}};
  assign accept   = |in_ready;

  // Output register reloads on accept; otherwise drains on a completed output transfer.
  always_comb begin
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef MUX_NTO1_LAST_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (accept) begin
      out_data_d  = gnt_data;
      out_last_d  = gnt_last;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (arb_mode) rr_ptr_d = SEL_WIDTH'((32'(gnt_idx) + 1) % NUM_CH);
`ifdef MUX_NTO1_LAST_LOCK_EN
      lock_d    = !gnt_last;
      lock_ch_d = gnt_idx;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
`ifdef MUX_NTO1_LAST_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_NTO1_LAST_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Bench for mux_nto1_stream: directed scenarios then random traffic against a behavioural model and beat scoreboard.
// Follows MUX_NTO1_LAST_LOCK_EN the same way as the design.
module tb_mux_nto1_stream;
  localparam int unsigned W  = 64;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;
`ifdef MUX_NTO1_LAST_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [SW-1:0]  sel;
  logic           arb_mode;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_ch;
  logic           out_valid, out_ready;

  logic [23:0]    in_data3;
  logic [2:0]     in_valid3, in_last3, in_ready3;
  logic [1:0]     sel3, out_ch3;
  logic           arb3;
  logic [7:0]     out_data3;
  logic           out_last3, out_valid3, out_ready3;

  mux_nto1_stream #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sel(sel), .arb_mode(arb_mode), .out_data(out_data),
    .out_last(out_last), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready));

  mux_nto1_stream #(.WIDTH(8), .NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
    .in_ready(in_ready3), .sel(sel3), .arb_mode(arb3), .out_data(out_data3),
    .out_last(out_last3), .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit            m_valid;
  logic [W-1:0]  m_data;
  bit            m_last;
  int            m_ch, m_ptr, m_lock_ch, last_acc;
  bit            m_lock;
  logic [65:0]   sbq[$];

  int exp_lock_seq[4]   = '{0, 0, 0, 1};
  int exp_nolock_seq[4] = '{0, 1, 0, 1};

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] g = '0;
    if (!rst_n || (m_valid && !out_ready)) return '0;
    if (LOCK_EN && m_lock) begin
      g[m_lock_ch] = in_valid[m_lock_ch];
      return g;
    end
    if (!arb_mode) begin
      if (int'(sel) < N) g[sel] = in_valid[sel];
    end else begin
      for (int k = 0; k < N; k++) begin
        if (in_valid[(m_ptr + k) % N]) begin
          g[(m_ptr + k) % N] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic model_edge(input logic [N-1:0] acc);
    int c;
    last_acc = -1;
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_last = 0; m_ch = 0; m_ptr = 0; m_lock = 0; m_lock_ch = 0;
      sbq.delete();
      return;
    end
    if (acc != '0) begin
      c = $clog2(acc);
      last_acc = c;
      m_valid = 1; m_data = in_data[c*W +: W]; m_last = in_last[c]; m_ch = c;
      sbq.push_back({2'(c), in_data[c*W +: W]});
      if (arb_mode) m_ptr = (c + 1) % N;
      m_lock = !in_last[c];
      m_lock_ch = c;
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  // One clock: check combinational ready, consume scoreboard, advance edge, check registers.
  task automatic step(output logic [N-1:0] rdy_seen);
    logic [N-1:0] er;
    logic [65:0]  e;
    #1;
    er = exp_ready();
    rdy_seen = in_ready;
    chk("in_ready", 66'(in_ready), 66'(er));
    chk("in_ready_n3", 66'(in_ready3), 66'(0));
    if (rst_n && m_valid && out_ready && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_beat", {out_ch, out_data}, e);
    end
    @(posedge clk);
    model_edge(er);
    #1;
    chk("out_valid", 66'(out_valid), 66'(m_valid));
    chk("out_data", 66'(out_data), 66'(m_data));
    chk("out_last", 66'(out_last), 66'(m_last));
    chk("out_ch", 66'(out_ch), 66'(m_ch));
    chk("out_valid_n3", 66'(out_valid3), 66'(0));
  endtask

  initial begin
    logic [N-1:0] rdy;
    int b0;
    rst_n = 0; in_data = '0; in_valid = '0; in_last = '0; sel = '0; arb_mode = 0; out_ready = 1;
    in_data3 = 24'hABCDEF; in_valid3 = 3'b111; in_last3 = 3'b111; sel3 = 2'd3; arb3 = 0; out_ready3 = 1;

    // Reset
    step(rdy); step(rdy);
    chk("rst_rdy", 66'(rdy), 66'(0));
    chk("rst_out_data", 66'(out_data), 66'(0));
    rst_n = 1;

    // Select mode, sel=2
    in_last = 4'b1111; sel = 2'd2; in_valid = 4'b0111;
    in_data[2*W +: W] = 64'hA5A5_0000_0000_0002;
    step(rdy);
    chk("sel_rdy", 66'(rdy), 66'(4'b0100));
    chk("sel_data", 66'(out_data), 66'(64'hA5A5_0000_0000_0002));
    chk("sel_ch", 66'(out_ch), 66'(2));

    // Round-robin, all valid
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 64'hC0DE_0000_0000_0000 | 64'(i);
    arb_mode = 1; in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step(rdy);
      chk("rr_ch", 66'(out_ch), 66'(i % N));
      chk("rr_valid", 66'(out_valid), 66'(1));
    end

    // Backpressure with channel 1 waiting
    arb_mode = 0; sel = 2'd1; in_valid = 4'b0010; out_ready = 0;
    in_data[1*W +: W] = 64'hBEEF_0000_0000_0011;
    for (int i = 0; i < 3; i++) begin
      step(rdy);
      chk("bp_rdy", 66'(rdy), 66'(0));
      chk("bp_hold", 66'(out_data), 66'(64'hC0DE_0000_0000_0001));
    end
    out_ready = 1;
    step(rdy);
    chk("bp_release_rdy", 66'(rdy), 66'(4'b0010));
    chk("bp_release_data", 66'(out_data), 66'(64'hBEEF_0000_0000_0011));

    // Reset mid-stream with pointer at 3
    arb_mode = 1; in_valid = 4'b1111;
    step(rdy);
    chk("pre_rst_ch", 66'(out_ch), 66'(2));
    rst_n = 0;
    step(rdy);
    chk("mid_rst_rdy", 66'(rdy), 66'(0));
    chk("mid_rst_valid", 66'(out_valid), 66'(0));
    chk("mid_rst_data", 66'(out_data), 66'(0));
    rst_n = 1;
    step(rdy);
    chk("post_rst_ch", 66'(out_ch), 66'(0));

    // Packet lock: channel 0 sends last=0,0,1 while channel 1 stays valid
    rst_n = 0; step(rdy); rst_n = 1;
    arb_mode = 1; out_ready = 1; in_valid = 4'b0011; in_last = 4'b0010; b0 = 0;
    in_data[1*W +: W] = 64'h1111;
    for (int i = 0; i < 4; i++) begin
      in_last[0] = (b0 == 2);
      in_data[0 +: W] = 64'(b0);
      step(rdy);
      chk("lock_seq", 66'(out_ch), 66'(LOCK_EN ? exp_lock_seq[i] : exp_nolock_seq[i]));
      if (last_acc == 0) b0++;
      if (b0 == 3) in_valid[0] = 1'b0;
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      in_valid  = N'($urandom);
      in_last   = N'($urandom);
      sel       = SW'($urandom);
      arb_mode  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) in_data[c*W +: W] = {$urandom, $urandom};
      step(rdy);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
